stopwatch_ctrl: RTL

Sequencing core of the stopwatch IP. It converts single-cycle command pulses from the AXI-lite register block into a RUN/PAUSE/IDLE state machine, and prescales ACLK into 10 ms ticks. It drives a BCD mm:ss.cc time counter and a lap capture register, and raises one-cycle event pulses into the interrupt controller (global enable, interrupt enable, pending, ack).

---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/stopwatch_bcd_digit.sv | 35 +++
 rtl/stopwatch_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencing core.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10
   } sw_state_t;

   typedef logic [3:0] bcd_digit_t;

   // mm:ss.cc, most significant digit first
   typedef struct packed {
      bcd_digit_t m10;
      bcd_digit_t m1;
      bcd_digit_t s10;
      bcd_digit_t s1;
      bcd_digit_t c10;
      bcd_digit_t c1;
   } sw_time_t;

   localparam int unsigned SW_DIGIT_MAX_DEC = 9;
   localparam int unsigned SW_DIGIT_MAX_SEX = 5;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit of the time counter: counts 0..MAX on inc and wraps,
// with a combinational carry into the next more significant digit.
module stopwatch_bcd_digit
   import stopwatch_pkg::*;
#(
   parameter int unsigned MAX = SW_DIGIT_MAX_DEC
) (
   input  logic       ACLK,
   input  logic       ARESET,
   input  logic       clr,
   input  logic       inc,
   output bcd_digit_t digit,
   output logic       carry
);

   localparam bcd_digit_t MAX_D = bcd_digit_t'(MAX);

   bcd_digit_t digit_q;

   // Digit register: clear wins over increment, wrap to zero at MAX.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         digit_q <= '0;
      end else if (clr) begin
         digit_q <= '0;
      end else if (inc) begin
         if (digit_q == MAX_D) digit_q <= '0;
         else                  digit_q <= digit_q + 4'd1;
      end
   end

   assign digit = digit_q;
   assign carry = inc && (digit_q == MAX_D);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing core: command FSM, centisecond prescaler,
// BCD mm:ss.cc counter, lap capture and one-cycle event pulses.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 1000000,
   parameter int unsigned LAP_CNT_W = 8
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   input  logic                 cmd_start,
   input  logic                 cmd_stop,
   input  logic                 cmd_lap,
   input  logic                 cmd_clear,
   output logic [23:0]          time_bcd,
   output logic [23:0]          lap_bcd,
   output logic                 lap_valid,
   output logic [LAP_CNT_W-1:0] lap_count,
   output logic [1:0]           state,
   output logic                 running,
   output logic                 irq_lap,
   output logic                 irq_wrap
);

   localparam int unsigned      PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

   sw_state_t            state_q, state_d;
   logic [PRESC_W-1:0]   presc_q;
   logic                 tick;
   sw_time_t             cur_time;
   logic [23:0]          lap_bcd_q;
   logic                 lap_valid_q;
   logic [LAP_CNT_W-1:0] lap_count_q;
   logic                 irq_lap_q, irq_wrap_q;
   logic                 lap_evt, wrap_evt;

   bcd_digit_t d_c1, d_c10, d_s1, d_s10, d_m1, d_m10;
   logic       cy_c1, cy_c10, cy_s1, cy_s10, cy_m1, cy_m10;

   // State register; an unreachable encoding falls back to IDLE via next-state logic.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state: clear > stop > start; redundant commands leave the state alone.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!cmd_clear && cmd_start) state_d = RUN;
         end
         RUN: begin
            if (cmd_clear)     state_d = IDLE;
            else if (cmd_stop) state_d = PAUSE;
         end
         PAUSE: begin
            if (cmd_clear)      state_d = IDLE;
            else if (cmd_stop)  state_d = PAUSE;
            else if (cmd_start) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // Prescaler: advances only in RUN, holds its phase in PAUSE, zeroed by clear.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         presc_q <= '0;
      end else if (cmd_clear) begin
         presc_q <= '0;
      end else if (state_q == RUN) begin
         if (presc_q == PRESC_MAX) presc_q <= '0;
         else                      presc_q <= presc_q + PRESC_W'(1);
      end
   end

   // Tick decision uses the current state, so a stop in the tick cycle still counts.
   assign tick = (state_q == RUN) && (presc_q == PRESC_MAX);

   stopwatch_bcd_digit #(.MAX(SW_DIGIT_MAX_DEC)) u_c1 (
      .ACLK(ACLK), .ARESET(ARESET), .clr(cmd_clear), .inc(tick),
      .digit(d_c1), .carry(cy_c1));
   stopwatch_bcd_digit #(.MAX(SW_DIGIT_MAX_DEC)) u_c10 (
      .ACLK(ACLK), .ARESET(ARESET), .clr(cmd_clear), .inc(cy_c1),
      .digit(d_c10), .carry(cy_c10));
   stopwatch_bcd_digit #(.MAX(SW_DIGIT_MAX_DEC)) u_s1 (
      .ACLK(ACLK), .ARESET(ARESET), .clr(cmd_clear), .inc(cy_c10),
      .digit(d_s1), .carry(cy_s1));
   stopwatch_bcd_digit #(.MAX(SW_DIGIT_MAX_SEX)) u_s10 (
      .ACLK(ACLK), .ARESET(ARESET), .clr(cmd_clear), .inc(cy_s1),
      .digit(d_s10), .carry(cy_s10));
   stopwatch_bcd_digit #(.MAX(SW_DIGIT_MAX_DEC)) u_m1 (
      .ACLK(ACLK), .ARESET(ARESET), .clr(cmd_clear), .inc(cy_s10),
      .digit(d_m1), .carry(cy_m1));
   stopwatch_bcd_digit #(.MAX(SW_DIGIT_MAX_SEX)) u_m10 (
      .ACLK(ACLK), .ARESET(ARESET), .clr(cmd_clear), .inc(cy_m1),
      .digit(d_m10), .carry(cy_m10));

   assign cur_time = '{m10: d_m10, m1: d_m1, s10: d_s10, s1: d_s1, c10: d_c10, c1: d_c1};

   // Clear swallows every event raised in its own cycle.
   assign lap_evt  = cmd_lap && !cmd_clear && ((state_q == RUN) || (state_q == PAUSE));
   assign wrap_evt = cy_m10 && !cmd_clear;

   // Lap capture takes the pre-increment time and counts laps with saturation.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         lap_bcd_q   <= '0;
         lap_valid_q <= 1'b0;
         lap_count_q <= '0;
      end else if (cmd_clear) begin
         lap_bcd_q   <= '0;
         lap_valid_q <= 1'b0;
         lap_count_q <= '0;
      end else if (lap_evt) begin
         lap_bcd_q   <= cur_time;
         lap_valid_q <= 1'b1;
         if (lap_count_q != '1) lap_count_q <= lap_count_q + LAP_CNT_W'(1);
      end
   end

   // Event pulses: registered, exactly one cycle per event.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         irq_lap_q  <= 1'b0;
         irq_wrap_q <= 1'b0;
      end else begin
         irq_lap_q  <= lap_evt;
         irq_wrap_q <= wrap_evt;
      end
   end

   assign time_bcd  = cur_time;
   assign lap_bcd   = lap_bcd_q;
   assign lap_valid = lap_valid_q;
   assign lap_count = lap_count_q;
   assign state     = state_q;
   assign running   = (state_q == RUN);
   assign irq_lap   = irq_lap_q;
   assign irq_wrap  = irq_wrap_q;

endmodule
